dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the pipeline's M stage. Serves one 8-byte read or write per request over a valid/ready handshake.
//  Inserts a configurable number of wait states and flags out-of-range addresses so the core can raise memory-error status (3'b011).
//  Sits between the memory stage (initiator) and a byte-addressed little-endian RAM array.
// PARAMETERS
//  MEM_BYTES    1024  size of byte-addressed RAM array; valid quad addresses are 0..MEM_BYTES-8
//  WAIT_CYCLES  1     wait states between request accept and response (legal range 0..15)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   synchronous active-low reset
//  req_valid  in   1   initiator presents a request
//  req_ready  out  1   responder can accept a request
//  req_write  in   1   1 = write quad, 0 = read quad
//  req_addr   in   64  byte address of the quad (little-endian, addr = LSB)
//  req_wdata  in   64  write data
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   initiator accepts the response
//  rsp_rdata  out  64  read data; 0 for writes and errors
//  rsp_err    out  1   address out of range (or misaligned, see CONFIGURATION)
//  busy       out  1   request in flight (state != IDLE)
// BEHAVIOUR
//  - Interface: one clock (clk); reset is synchronous and active-low (rst_n).
//  - Reset (rst_n low at clk edge): state=IDLE, wait counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0.
//    req_ready is forced to 0 while rst_n is low. The RAM array is NOT cleared.
//  - FSM states:
//    - IDLE: req_ready=1.
//    - WAIT: req_ready=0. Counter runs.
//    - RESP: req_ready=0, rsp_valid=1.
//  - Accept in IDLE when req_valid and req_ready at a clk edge. Latch write, addr and wdata into registers; later changes on req_* are ignored.
//  - Transitions:
//    - IDLE -> WAIT (counter loaded with WAIT_CYCLES-1) if WAIT_CYCLES>0.
//    - IDLE -> RESP if WAIT_CYCLES==0.
//    - WAIT: decrement the counter each cycle; go to RESP on the edge where the counter is 0.
//  - Latency: rsp_valid rises exactly WAIT_CYCLES+1 edges after the accept edge.
//  - Commit: the RAM read/write happens on the same edge that enters RESP. rsp_rdata and rsp_err are registered on that edge.
//  - RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready is seen at an edge, then go to IDLE with rsp_valid=0.
//    The next request can be accepted one edge after that, so there is one outstanding request maximum and no back-to-back accept.
//  - Range check: err = ({1'b0,addr}+65'd8 > MEM_BYTES). The 65-bit add means addresses near 2^64 do not wrap into range.
//    On err, no RAM write is performed and rsp_rdata=0.
//  - Byte order: a quad spans addr..addr+7, with addr holding bits [7:0].
//  - Reset mid-operation:
//    - In WAIT: the request is dropped and no write is committed.
//    - In RESP: the already-committed write stands and the response is discarded.
//  - rsp_ready asserted outside RESP is ignored. req_valid during WAIT/RESP is not accepted; the initiator must hold it.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//    - req_addr[2:0]!=0 also sets rsp_err=1, suppresses the write and returns rsp_rdata=0.
//    - Latency is unchanged.
//  DMEM_ALIGN_CHECK_EN undefined:
//    - Unaligned quads are legal and byte-granular.
//    - Only the range check applies.
// TESTING
//  1. Reset: hold rst_n=0 for 2 edges with req_valid=1 -> req_ready=0, rsp_valid=0, busy=0, no accept; after release req_ready=1.
//  2. Write then read, WAIT_CYCLES=1:
//     - write addr=0x10, wdata=0x1122334455667788 -> rsp_valid 2 edges after accept, rsp_err=0, rsp_rdata=0.
//     - read addr=0x10 -> rsp_rdata=0x1122334455667788.
//     - byte at 0x10 == 0x88.
//  3. Backpressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid and rsp_rdata stable, req_ready=0; release -> IDLE next edge.
//  4. Range:
//     - MEM_BYTES=1024, read addr=1016 -> rsp_err=0.
//     - addr=1017 -> rsp_err=1, rsp_rdata=0.
//     - write to addr=0xFFFFFFFFFFFFFFFC -> rsp_err=1, RAM unchanged.
//  5. Zero wait: WAIT_CYCLES=0 -> rsp_valid 1 edge after accept; WAIT_CYCLES=15 -> 16 edges.
//  6. Reset mid-WAIT on a write of 0xDEAD to 0x20 -> returns IDLE, later read of 0x20 returns the old value.
//     With DMEM_ALIGN_CHECK_EN: read 0x21 -> rsp_err=1.

Source files
------------

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between the M stage (master) and dmem_responder (slave)
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - M-stage 8-byte data-memory responder with wait states and range check
// Optional DMEM_ALIGN_CHECK_EN also flags quads whose address is not 8-byte aligned.
module dmem_responder #(
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);
  localparam int         AW       = $clog2(MEM_BYTES);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [63:0] rsp_rdata_q;
  logic [7:0]  mem [MEM_BYTES];

  logic        accept;
  logic        commit;
  logic        cmd_write;
  logic [63:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        range_err;
  logic        cmd_err;
  logic [AW-1:0] base;
  logic [63:0] rd_quad;

  assign bus.req_ready = rst_n && (state == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  // With zero wait states the commit happens on the accept edge, so the live request is used.
  assign cmd_write = (state == IDLE) ? bus.req_write : lat_write;
  assign cmd_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
  assign cmd_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;

  // 65-bit sum keeps addresses near 2^64 from wrapping back into range.
  assign range_err = ({1'b0, cmd_addr} + 65'd8) > 65'(MEM_BYTES);

`ifdef DMEM_ALIGN_CHECK_EN
  logic align_err;
  assign align_err = (cmd_addr[2:0] != 3'd0);
  assign cmd_err   = range_err || align_err;
`else
  assign cmd_err   = range_err;
`endif

  assign base   = cmd_addr[AW-1:0];
  assign commit = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                  ((state == WAIT) && (cnt == 4'd0));

  always_comb begin
    rd_quad = '0;
    for (int i = 0; i < 8; i++) begin
      rd_quad[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && commit && cmd_write && !cmd_err) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= cmd_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (commit) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= cmd_err;
        rsp_rdata_q <= (cmd_err || cmd_write) ? 64'd0 : rd_quad;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder against a transaction-level memory model
module tb_dmem_responder;
  localparam int MB = 1024;
  localparam int W  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();
  dmem_responder_if bus0();
  dmem_responder_if bus15();

  dmem_responder #(.MEM_BYTES(MB), .WAIT_CYCLES(W))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  dmem_responder #(.MEM_BYTES(MB), .WAIT_CYCLES(0))  dut0  (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dmem_responder #(.MEM_BYTES(MB), .WAIT_CYCLES(15)) dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request is in flight from accept until the response handshake.
  bit          m_busy = 1'b0;
  int          m_el   = 0;
  bit          m_w;
  logic [63:0] m_a, m_d;
  logic [63:0] m_rdata = '0;
  bit          m_err   = 1'b0;
  logic [7:0]  m_mem [MB];

  function automatic bit exp_err(input logic [63:0] a);
    bit e;
    e = (a > 64'(MB - 8));
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[2:0] != 3'd0) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic model_commit();
    if (exp_err(m_a)) begin
      m_err = 1'b1; m_rdata = '0;
    end else if (m_w) begin
      for (int i = 0; i < 8; i++) m_mem[int'(m_a) + i] = m_d[8*i +: 8];
      m_err = 1'b0; m_rdata = '0;
    end else begin
      m_err = 1'b0; m_rdata = '0;
      for (int i = 0; i < 8; i++) m_rdata[8*i +: 8] = m_mem[int'(m_a) + i];
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (bus.req_valid) begin
        m_busy = 1'b1; m_el = 0;
        m_w = bus.req_write; m_a = bus.req_addr; m_d = bus.req_wdata;
        if (W == 0) model_commit();
      end
    end else if (m_el >= W) begin
      if (bus.rsp_ready) m_busy = 1'b0;
    end else begin
      m_el++;
      if (m_el == W) model_commit();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", bus.req_ready, rst_n && !m_busy);
      check("busy", bus.busy, m_busy);
      check("rsp_valid", bus.rsp_valid, m_busy && (m_el >= W));
      if (m_busy && (m_el >= W)) begin
        check("rsp_rdata", bus.rsp_rdata, m_rdata);
        check("rsp_err", bus.rsp_err, m_err);
      end
    end
  end

  task automatic xact(input bit w, input logic [63:0] a, input logic [63:0] d, input int hold,
                      output logic [63:0] rd, output bit er, output int lat);
    int n;
    rd = '0; er = 1'b0; lat = 0; n = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d; bus.rsp_ready = 1'b0;
    do begin @(negedge clk); n++; end while (!bus.req_ready && n < 50);
    if (!bus.req_ready) begin
      check("accept_timeout", 1'b0, 1'b1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_write = 1'($urandom);
    bus.req_addr = {$urandom, $urandom}; bus.req_wdata = {$urandom, $urandom};
    do begin
      @(negedge clk); lat++;
      if (!bus.rsp_valid) bus.rsp_ready = 1'($urandom);
    end while (!bus.rsp_valid && lat < 40);
    if (!bus.rsp_valid) begin
      check("rsp_timeout", 1'b0, 1'b1);
      return;
    end
    rd = bus.rsp_rdata; er = bus.rsp_err;
    bus.rsp_ready = (hold == 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_rsp_valid", bus.rsp_valid, 1'b1);
      check("hold_req_ready", bus.req_ready, 1'b0);
      if (k == hold - 1) bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("release_rsp_valid", bus.rsp_valid, 1'b0);
    check("release_req_ready", bus.req_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    bit          er;
    int          lat;
    for (int i = 0; i < MB; i++) m_mem[i] = '0;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_wdata = 0; bus0.rsp_ready = 0;
    bus15.req_valid = 0; bus15.req_write = 0; bus15.req_addr = 0; bus15.req_wdata = 0; bus15.rsp_ready = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 64'h10; bus.req_wdata = 64'h55; bus.rsp_ready = 1'b0;

    repeat (2) begin
      @(posedge clk); #1 chk_en = 1'b1;
      @(negedge clk);
      check("reset_req_ready", bus.req_ready, 1'b0);
      check("reset_rsp_valid", bus.rsp_valid, 1'b0);
      check("reset_busy", bus.busy, 1'b0);
    end
    #1 bus.req_valid = 1'b0; rst_n = 1'b1;
    #1 check("post_reset_req_ready", bus.req_ready, 1'b1);

    for (int i = 0; i < MB / 8; i++) xact(1'b1, 64'(i * 8), {$urandom, $urandom}, 0, rd, er, lat);

    xact(1'b1, 64'h10, 64'h1122334455667788, 0, rd, er, lat);
    check("wr10_latency", lat, 2);
    check("wr10_err", er, 1'b0);
    check("wr10_rdata", rd, 64'd0);
    xact(1'b0, 64'h10, 64'd0, 0, rd, er, lat);
    check("rd10_rdata", rd, 64'h1122334455667788);
    check("rd10_err", er, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    xact(1'b0, 64'h21, 64'd0, 0, rd, er, lat);
    check("rd21_err", er, 1'b1);
    check("rd21_rdata", rd, 64'd0);
`else
    xact(1'b0, 64'h0F, 64'd0, 0, rd, er, lat);
    check("byte10", rd[15:8], 8'h88);
`endif

    xact(1'b0, 64'h10, 64'd0, 5, rd, er, lat);
    check("bp_rdata", rd, 64'h1122334455667788);

    xact(1'b1, 64'd1016, 64'h0102030405060708, 0, rd, er, lat);
    check("wr1016_err", er, 1'b0);
    xact(1'b0, 64'd1016, 64'd0, 0, rd, er, lat);
    check("rd1016_err", er, 1'b0);
    check("rd1016_rdata", rd, 64'h0102030405060708);
    xact(1'b0, 64'd1017, 64'd0, 0, rd, er, lat);
    check("rd1017_err", er, 1'b1);
    check("rd1017_rdata", rd, 64'd0);
    xact(1'b1, 64'hFFFFFFFFFFFFFFFC, 64'hA5A5A5A5A5A5A5A5, 0, rd, er, lat);
    check("wrhigh_err", er, 1'b1);
    xact(1'b0, 64'd1016, 64'd0, 0, rd, er, lat);
    check("rd1016_unchanged", rd, 64'h0102030405060708);

    xact(1'b1, 64'h20, 64'hCAFEF00D12345678, 0, rd, er, lat);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 64'h20; bus.req_wdata = 64'hDEAD;
    @(negedge clk); check("midwait_accept_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1 bus.req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); check("midwait_busy", bus.busy, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midwait_idle_busy", bus.busy, 1'b0);
    check("midwait_idle_ready", bus.req_ready, 1'b1);
    xact(1'b0, 64'h20, 64'd0, 0, rd, er, lat);
    check("midwait_old_value", rd, 64'hCAFEF00D12345678);

    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 64'h30; bus.req_wdata = 64'h0BADBEEF00000030;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); check("midresp_valid", bus.rsp_valid, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("midresp_dropped", bus.rsp_valid, 1'b0);
    xact(1'b0, 64'h30, 64'd0, 0, rd, er, lat);
    check("midresp_committed", rd, 64'h0BADBEEF00000030);

    for (int t = 0; t < 300; t++) begin
      int          sel;
      logic [63:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 64'($urandom_range(0, MB - 8));
      else if (sel < 9) a = 64'($urandom_range(MB - 7, MB - 1));
      else              a = {$urandom, $urandom};
      xact(1'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 3), rd, er, lat);
      check("rand_latency", lat, W + 1);
    end

    @(posedge clk); #1;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 64'h8; bus0.req_wdata = 64'h1;
    @(negedge clk); check("w0_req_ready", bus0.req_ready, 1'b1);
    @(posedge clk); #1 bus0.req_valid = 1'b0; lat = 0;
    do begin @(negedge clk); lat++; end while (!bus0.rsp_valid && lat < 40);
    check("w0_latency", lat, 1);
    check("w0_err", bus0.rsp_err, 1'b0);
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1 bus0.rsp_ready = 1'b0;
    @(negedge clk); check("w0_release", bus0.rsp_valid, 1'b0);

    @(posedge clk); #1;
    bus15.req_valid = 1'b1; bus15.req_write = 1'b1; bus15.req_addr = 64'h8; bus15.req_wdata = 64'h1;
    @(negedge clk); check("w15_req_ready", bus15.req_ready, 1'b1);
    @(posedge clk); #1 bus15.req_valid = 1'b0; lat = 0;
    do begin @(negedge clk); lat++; end while (!bus15.rsp_valid && lat < 40);
    check("w15_latency", lat, 16);
    check("w15_err", bus15.rsp_err, 1'b0);
    bus15.rsp_ready = 1'b1;
    @(posedge clk); #1 bus15.rsp_ready = 1'b0;
    @(negedge clk); check("w15_release", bus15.rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
